// File: rtl/comba_mult_arb_if.sv
// Requester-fabric and multiplier-facing bus of comba_mult_arb.
// Signal suffixes are from the arbiter's point of view; slave = arbiter, master = environment.
interface comba_mult_arb_if #(
  parameter int NUM_REQ = 4,
  parameter int A_WIDTH = 64,
  parameter int B_WIDTH = 64,
  localparam int MULT_WIDTH = A_WIDTH + B_WIDTH
);
  logic [NUM_REQ-1:0]         req_valid_i;
  logic [NUM_REQ*A_WIDTH-1:0] req_a_i;
  logic [NUM_REQ*B_WIDTH-1:0] req_b_i;
  logic [NUM_REQ-1:0]         req_ready_o;
  logic [NUM_REQ-1:0]         resp_valid_o;
  logic [MULT_WIDTH-1:0]      resp_result_o;
  logic [NUM_REQ-1:0]         resp_ready_i;
  logic                       mult_valid_o;
  logic [A_WIDTH-1:0]         mult_a_o;
  logic [B_WIDTH-1:0]         mult_b_o;
  logic                       mult_ready_i;
  logic                       mult_valid_i;
  logic [MULT_WIDTH-1:0]      mult_result_i;
  logic                       mult_ready_o;

  modport slave (
    input  req_valid_i, req_a_i, req_b_i, resp_ready_i,
    input  mult_ready_i, mult_valid_i, mult_result_i,
    output req_ready_o, resp_valid_o, resp_result_o,
    output mult_valid_o, mult_a_o, mult_b_o, mult_ready_o
  );

  modport master (
    output req_valid_i, req_a_i, req_b_i, resp_ready_i,
    output mult_ready_i, mult_valid_i, mult_result_i,
    input  req_ready_o, resp_valid_o, resp_result_o,
    input  mult_valid_o, mult_a_o, mult_b_o, mult_ready_o
  );
endinterface

// File: rtl/comba_mult_arb.sv
// Shares one comba_mult among NUM_REQ requesters; an in-order tag FIFO routes results back.
// Define COMBA_ARB_RR_EN for round-robin arbitration, otherwise the lowest-index candidate wins.
module comba_mult_arb #(
  parameter int NUM_REQ   = 4,
  parameter int A_WIDTH   = 64,
  parameter int B_WIDTH   = 64,
  parameter int TAG_DEPTH = 8,
  localparam int MULT_WIDTH = A_WIDTH + B_WIDTH,
  localparam int IDW        = $clog2(NUM_REQ),
  localparam int CW         = $clog2(TAG_DEPTH + 1)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  comba_mult_arb_if.slave bus,
  output logic [CW-1:0]   outstanding_o,
  output logic            err_o
);
  localparam int PW = $clog2(TAG_DEPTH);

  logic [A_WIDTH-1:0] a_slice [NUM_REQ];
  logic [B_WIDTH-1:0] b_slice [NUM_REQ];

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
      assign a_slice[gi] = bus.req_a_i[gi*A_WIDTH +: A_WIDTH];
      assign b_slice[gi] = bus.req_b_i[gi*B_WIDTH +: B_WIDTH];
    end
  endgenerate

  logic [IDW-1:0] tag_mem [TAG_DEPTH];

  logic [CW-1:0]  count_q, count_d;
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic           lock_q, lock_d;
  logic [IDW-1:0] lock_id_q, lock_id_d;
  logic           err_q, err_d;
`ifdef COMBA_ARB_RR_EN
  logic [IDW-1:0] rr_q, rr_d;
`endif

  logic               full;
  logic               empty;
  logic [NUM_REQ-1:0] cand;
  logic [IDW-1:0]     grant;
  logic               issue_valid;
  logic               issue_hs;
  logic [IDW-1:0]     head;
  logic               ret_hs;

  function automatic logic [IDW-1:0] fixed_pick(input logic [NUM_REQ-1:0] c);
    logic [IDW-1:0] sel;
    sel = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (c[i]) sel = IDW'(i);
    end
    return sel;
  endfunction

`ifdef COMBA_ARB_RR_EN
  // Walk offsets downward so the candidate nearest to start is assigned last and wins.
  function automatic logic [IDW-1:0] rr_pick(input logic [NUM_REQ-1:0] c,
                                             input logic [IDW-1:0]     start);
    logic [IDW-1:0] sel;
    int             idx;
    sel = start;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = int'(start) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (c[idx]) sel = IDW'(idx);
    end
    return sel;
  endfunction
`endif

  // Issue path: a held grant stays on its requester until the handshake or until it drops valid.
  always_comb begin
    full        = (count_q == CW'(TAG_DEPTH));
    cand        = bus.req_valid_i & ~{NUM_REQ{full}};
    grant       = '0;
    issue_valid = 1'b0;
    if (lock_q) begin
      grant       = lock_id_q;
      issue_valid = cand[lock_id_q];
    end else begin
`ifdef COMBA_ARB_RR_EN
      grant = rr_pick(cand, rr_q);
`else
      grant = fixed_pick(cand);
`endif
      issue_valid = |cand;
    end
    issue_hs         = issue_valid & bus.mult_ready_i;
    bus.mult_valid_o = issue_valid;
    bus.mult_a_o     = a_slice[grant];
    bus.mult_b_o     = b_slice[grant];
    bus.req_ready_o  = '0;
    bus.req_ready_o[grant] = issue_hs;
  end

  // Return path: the FIFO head names the requester that owns the result now at the multiplier output.
  always_comb begin
    empty             = (count_q == '0);
    head              = tag_mem[rd_ptr_q];
    bus.resp_valid_o  = '0;
    bus.resp_valid_o[head] = bus.mult_valid_i & ~empty;
    bus.resp_result_o = bus.mult_result_i;
    bus.mult_ready_o  = bus.resp_ready_i[head] & ~empty;
    ret_hs            = bus.mult_valid_i & bus.mult_ready_o;
  end

  always_comb begin
    count_d   = count_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    if (issue_hs) wr_ptr_d = wr_ptr_q + 1'b1;
    if (ret_hs)   rd_ptr_d = rd_ptr_q + 1'b1;
    case ({issue_hs, ret_hs})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    lock_d    = issue_valid & ~bus.mult_ready_i;
    lock_id_d = lock_d ? grant : lock_id_q;
    err_d     = err_q | (bus.mult_valid_i & empty);
`ifdef COMBA_ARB_RR_EN
    rr_d = rr_q;
    if (issue_hs) rr_d = (int'(grant) == NUM_REQ - 1) ? '0 : grant + 1'b1;
`endif
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      lock_q    <= 1'b0;
      lock_id_q <= '0;
      err_q     <= 1'b0;
`ifdef COMBA_ARB_RR_EN
      rr_q      <= '0;
`endif
    end else begin
      count_q   <= count_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
      err_q     <= err_d;
`ifdef COMBA_ARB_RR_EN
      rr_q      <= rr_d;
`endif
    end
  end

  // Tag storage needs no reset: entries are only read while the counter says they are live.
  always_ff @(posedge clk_i) begin
    if (issue_hs) tag_mem[wr_ptr_q] <= grant;
  end

  assign outstanding_o = count_q;
  assign err_o         = err_q;
endmodule

// File: tb/tb_comba_mult_arb.sv
// Bench for comba_mult_arb: queue-based reference model checked every cycle plus directed literal checks.
// Build with or without COMBA_ARB_RR_EN; the arbitration expectations follow the same macro.
module tb_comba_mult_arb;
  localparam int NUM_REQ   = 4;
  localparam int A_WIDTH   = 64;
  localparam int B_WIDTH   = 64;
  localparam int TAG_DEPTH = 8;
  localparam int MW        = A_WIDTH + B_WIDTH;
  localparam int CW        = $clog2(TAG_DEPTH + 1);
`ifdef COMBA_ARB_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [CW-1:0] outstanding;
  logic          err;

  comba_mult_arb_if #(.NUM_REQ(NUM_REQ), .A_WIDTH(A_WIDTH), .B_WIDTH(B_WIDTH)) bus ();

  comba_mult_arb #(
    .NUM_REQ(NUM_REQ), .A_WIDTH(A_WIDTH), .B_WIDTH(B_WIDTH), .TAG_DEPTH(TAG_DEPTH)
  ) dut (
    .clk_i(clk), .rst_i(rst), .bus(bus), .outstanding_o(outstanding), .err_o(err)
  );

  always #5 clk = ~clk;

  logic [NUM_REQ-1:0] req_valid, resp_ready;
  logic [A_WIDTH-1:0] a_arr [NUM_REQ];
  logic [B_WIDTH-1:0] b_arr [NUM_REQ];
  logic               mready, ret_en, stray;
  logic               mval;
  logic [MW-1:0]      mres;

  always_comb begin
    bus.req_valid_i   = req_valid;
    bus.resp_ready_i  = resp_ready;
    bus.mult_ready_i  = mready;
    bus.mult_valid_i  = mval;
    bus.mult_result_i = mres;
    bus.req_a_i       = '0;
    bus.req_b_i       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      bus.req_a_i[k*A_WIDTH +: A_WIDTH] = a_arr[k];
      bus.req_b_i[k*B_WIDTH +: B_WIDTH] = b_arr[k];
    end
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [MW-1:0] act, input logic [MW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [NUM_REQ-1:0] c, input int rr);
    int start;
    start = RR_EN ? rr : 0;
    for (int i = 0; i < NUM_REQ; i++)
      if (c[(start + i) % NUM_REQ]) return (start + i) % NUM_REQ;
    return 0;
  endfunction

  // Reference model state: outstanding owners in issue order, sticky error, held grant, rr start.
  int            m_tags[$];
  bit            m_err, m_lock;
  int            m_lock_id, m_rr;
  bit            iss_seen, ret_seen;
  logic [MW-1:0] iss_prod;

  always @(negedge clk) begin : model
    logic [NUM_REQ-1:0] cand, exp_rdy, exp_rv;
    int g, h;
    bit mv, full, empty, iss, mrdy;
    if (rst) begin
      m_tags.delete();
      m_err = 0; m_lock = 0; m_lock_id = 0; m_rr = 0;
    end
    full  = (m_tags.size() == TAG_DEPTH);
    empty = (m_tags.size() == 0);
    cand  = full ? '0 : req_valid;
    if (m_lock) begin
      g  = m_lock_id;
      mv = cand[g];
    end else begin
      g  = pick(cand, m_rr);
      mv = |cand;
    end
    iss     = mv && mready;
    exp_rdy = iss ? (NUM_REQ'(1) << g) : '0;
    h       = empty ? 0 : m_tags[0];
    exp_rv  = (mval && !empty) ? (NUM_REQ'(1) << h) : '0;
    mrdy    = !empty && resp_ready[h];

    chk("m_mult_valid", MW'(bus.mult_valid_o), MW'(mv));
    if (mv) begin
      chk("m_mult_a", MW'(bus.mult_a_o), MW'(a_arr[g]));
      chk("m_mult_b", MW'(bus.mult_b_o), MW'(b_arr[g]));
    end
    chk("m_req_ready", MW'(bus.req_ready_o), MW'(exp_rdy));
    chk("m_resp_valid", MW'(bus.resp_valid_o), MW'(exp_rv));
    chk("m_mult_ready", MW'(bus.mult_ready_o), MW'(mrdy));
    chk("m_resp_result", bus.resp_result_o, mres);
    chk("m_outstanding", MW'(outstanding), MW'(m_tags.size()));
    chk("m_err", MW'(err), MW'(m_err));

    iss_seen = iss && !rst;
    ret_seen = mval && mrdy && !rst;
    iss_prod = MW'(a_arr[g]) * MW'(b_arr[g]);
    if (!rst) begin
      if (ret_seen) void'(m_tags.pop_front());
      if (iss) m_tags.push_back(g);
      if (mval && empty) m_err = 1;
      m_lock    = mv && !mready;
      m_lock_id = g;
      if (iss) m_rr = (g + 1) % NUM_REQ;
    end
  end

  // Multiplier stand-in: returns products in issue order whenever ret_en allows.
  logic [MW-1:0] prod_q[$];
  initial begin
    mval = 1'b0;
    mres = '0;
    forever begin
      @(posedge clk);
      #2;
      if (rst) begin
        prod_q.delete();
      end else begin
        if (ret_seen && prod_q.size() > 0) void'(prod_q.pop_front());
        if (iss_seen) prod_q.push_back(iss_prod);
      end
      if (stray) begin
        mval = 1'b1; mres = MW'(128'hDEAD);
      end else if (ret_en && prod_q.size() > 0) begin
        mval = 1'b1; mres = prod_q[0];
      end else begin
        mval = 1'b0; mres = '0;
      end
    end
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = '0; stray = 1'b0; ret_en = 1'b0; mready = 1'b0; resp_ready = '1;
    next();
    next();
    rst = 1'b0;
  endtask

  logic [NUM_REQ-1:0] exp_g [5];

  initial begin
    rst = 1'b1; req_valid = '0; resp_ready = '1; mready = 1'b0; ret_en = 1'b0; stray = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin a_arr[k] = '0; b_arr[k] = '0; end
    next();
    @(negedge clk);
    chk("rst_outstanding", MW'(outstanding), 0);
    chk("rst_err", MW'(err), 0);
    chk("rst_mult_valid", MW'(bus.mult_valid_o), 0);
    chk("rst_req_ready", MW'(bus.req_ready_o), 0);
    chk("rst_resp_valid", MW'(bus.resp_valid_o), 0);
    chk("rst_mult_ready", MW'(bus.mult_ready_o), 0);
    next();
    rst = 1'b0;

    // Single request from requester 2: 3*5.
    a_arr[2] = 3; b_arr[2] = 5; req_valid = 4'b0100; mready = 1'b1;
    @(negedge clk);
    chk("t1_mult_valid", MW'(bus.mult_valid_o), 1);
    chk("t1_mult_a", MW'(bus.mult_a_o), 3);
    chk("t1_mult_b", MW'(bus.mult_b_o), 5);
    chk("t1_req_ready", MW'(bus.req_ready_o), 4'b0100);
    next(); req_valid = '0;
    @(negedge clk);
    chk("t1_outstanding1", MW'(outstanding), 1);
    chk("t1_no_resp", MW'(bus.resp_valid_o), 0);
    next(); ret_en = 1'b1;
    @(negedge clk);
    chk("t1_resp_valid", MW'(bus.resp_valid_o), 4'b0100);
    chk("t1_result", bus.resp_result_o, 15);
    chk("t1_mult_ready", MW'(bus.mult_ready_o), 1);
    next(); ret_en = 1'b0;
    @(negedge clk);
    chk("t1_outstanding0", MW'(outstanding), 0);

    // All four requesting continuously.
    do_reset();
    for (int k = 0; k < NUM_REQ; k++) begin a_arr[k] = 64'(k + 1); b_arr[k] = 64'(100 + k); end
    mready = 1'b1; ret_en = 1'b1; req_valid = 4'b1111;
    if (RR_EN) begin
      exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b0100; exp_g[3] = 4'b1000; exp_g[4] = 4'b0001;
    end else begin
      for (int i = 0; i < 5; i++) exp_g[i] = 4'b0001;
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("t2_grant%0d", i), MW'(bus.req_ready_o), MW'(exp_g[i]));
      next();
    end
    req_valid = '0;
    repeat (4) next();
    @(negedge clk);
    chk("t2_drained", MW'(outstanding), 0);
    next();

    // Grant lock through a 3-cycle stall; requester 0 shows up mid-stall.
    do_reset();
    a_arr[1] = 64'h11; b_arr[1] = 2; a_arr[3] = 64'h33; b_arr[3] = 3; a_arr[0] = 64'h99; b_arr[0] = 4;
    mready = 1'b0; req_valid = 4'b1010;
    @(negedge clk);
    chk("t3_mult_valid", MW'(bus.mult_valid_o), 1);
    chk("t3_a_c0", MW'(bus.mult_a_o), 64'h11);
    chk("t3_ready_c0", MW'(bus.req_ready_o), 0);
    next(); req_valid = 4'b1011;
    @(negedge clk);
    chk("t3_a_c1", MW'(bus.mult_a_o), 64'h11);
    chk("t3_b_c1", MW'(bus.mult_b_o), 2);
    next();
    @(negedge clk);
    chk("t3_a_c2", MW'(bus.mult_a_o), 64'h11);
    next(); mready = 1'b1;
    @(negedge clk);
    chk("t3_ready_hs", MW'(bus.req_ready_o), 4'b0010);
    chk("t3_a_hs", MW'(bus.mult_a_o), 64'h11);
    next(); req_valid = 4'b1001;
    @(negedge clk);
    chk("t3_after_lock", MW'(bus.req_ready_o), RR_EN ? 4'b1000 : 4'b0001);
    next(); req_valid = '0; ret_en = 1'b1;
    repeat (4) next();

    // Fill the tag FIFO with the result side stalled.
    do_reset();
    a_arr[0] = 7; b_arr[0] = 9; mready = 1'b1; req_valid = 4'b0001;
    for (int i = 0; i < TAG_DEPTH; i++) begin
      @(negedge clk);
      chk($sformatf("t4_issue%0d", i), MW'(bus.req_ready_o), 4'b0001);
      next();
    end
    @(negedge clk);
    chk("t4_full", MW'(outstanding), 8);
    chk("t4_blocked", MW'(bus.req_ready_o), 0);
    chk("t4_mult_valid0", MW'(bus.mult_valid_o), 0);
    next(); ret_en = 1'b1;
    @(negedge clk);
    chk("t4_pop_ready", MW'(bus.mult_ready_o), 1);
    chk("t4_blocked_on_pop", MW'(bus.req_ready_o), 0);
    next(); ret_en = 1'b0;
    @(negedge clk);
    chk("t4_after_pop", MW'(outstanding), 7);
    chk("t4_resume", MW'(bus.req_ready_o), 4'b0001);
    next();
    @(negedge clk);
    chk("t4_refull", MW'(outstanding), 8);
    next(); req_valid = '0; ret_en = 1'b1;
    repeat (10) next();
    @(negedge clk);
    chk("t4_drained", MW'(outstanding), 0);
    next();

    // Results tagged 3 then 0, with requester 3 back-pressuring.
    do_reset();
    mready = 1'b1; a_arr[3] = 5; b_arr[3] = 6; req_valid = 4'b1000;
    next(); a_arr[0] = 7; b_arr[0] = 8; req_valid = 4'b0001;
    next(); req_valid = '0; resp_ready = 4'b0111; ret_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t5_stall_valid", MW'(bus.resp_valid_o), 4'b1000);
      chk("t5_stall_ready", MW'(bus.mult_ready_o), 0);
      chk("t5_stall_result", bus.resp_result_o, 30);
      next();
    end
    resp_ready = 4'b1111;
    @(negedge clk);
    chk("t5_r3_valid", MW'(bus.resp_valid_o), 4'b1000);
    chk("t5_r3_ready", MW'(bus.mult_ready_o), 1);
    next();
    @(negedge clk);
    chk("t5_r0_valid", MW'(bus.resp_valid_o), 4'b0001);
    chk("t5_r0_result", bus.resp_result_o, 56);
    next(); ret_en = 1'b0;
    @(negedge clk);
    chk("t5_drained", MW'(outstanding), 0);
    next();

    // Stray result, then a reset in the middle of traffic.
    do_reset();
    stray = 1'b1;
    @(negedge clk);
    chk("t6_stray_ready", MW'(bus.mult_ready_o), 0);
    chk("t6_stray_resp", MW'(bus.resp_valid_o), 0);
    chk("t6_err_before", MW'(err), 0);
    next(); stray = 1'b0;
    @(negedge clk);
    chk("t6_err_set", MW'(err), 1);
    next(); mready = 1'b1; a_arr[1] = 2; b_arr[1] = 2; req_valid = 4'b0010;
    next();
    @(negedge clk);
    chk("t6_err_sticky", MW'(err), 1);
    chk("t6_outst2", MW'(outstanding), 1);
    next(); rst = 1'b1; req_valid = '0;
    @(negedge clk);
    chk("t6_rst_err", MW'(err), 0);
    chk("t6_rst_outst", MW'(outstanding), 0);
    next(); rst = 1'b0;
    @(negedge clk);
    chk("t6_post_rst", MW'(outstanding), 0);
    next();
    next();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, vectors %0d", n_vec);
    $fatal(1, "watchdog expired");
  end
endmodule
